// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write scoreboard and EX/MEM write-port arbiter for the 32x64 register file.
// Ports: issue side (iss_valid/iss_ready, iss_rn/rm/rd, *_used, iss_rd_write),
//        EX and MEM writeback handshakes (valid/ready, rd, data), flush,
//        registered register-file write port (rf_we/rf_waddr/rf_wdata),
//        status: pend_cnt, stall_cnt (saturating), wb_err (sticky).
// Option: SCB_BYPASS_EN lets the hazard check see this cycle's grant clear (zero-bubble issue).
module reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64,
  parameter int ZERO_REG = 31,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] iss_rn,
  input  logic [ADDR_W-1:0] iss_rm,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_rn_used,
  input  logic              iss_rm_used,
  input  logic              iss_rd_write,
  input  logic              ex_wb_valid,
  output logic              ex_wb_ready,
  input  logic [ADDR_W-1:0] ex_wb_rd,
  input  logic [DATA_W-1:0] ex_wb_data,
  input  logic              mem_wb_valid,
  output logic              mem_wb_ready,
  input  logic [ADDR_W-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0] mem_wb_data,
  input  logic              flush,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [5:0]        pend_cnt,
  output logic [15:0]       stall_cnt,
  output logic              wb_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [NUM_REGS-1:0] pend, pend_n, clr, set, view;
  logic [SW-1:0] starve;
  logic force_ex, ex_grant, mem_grant, g_nz, haz, fire;
  logic [ADDR_W-1:0] g_rd;
  logic [DATA_W-1:0] g_data;
  logic [5:0] pc;
  assign force_ex = starve == SW'(STARVE_LIMIT);
  assign ex_wb_ready = !mem_wb_valid | force_ex;
  assign mem_wb_ready = !force_ex | !ex_wb_valid;
  // at most one grant per cycle: MEM by default, EX once it has starved
  assign ex_grant = ex_wb_valid & ex_wb_ready;
  assign mem_grant = mem_wb_valid & mem_wb_ready;
  assign g_rd = mem_grant ? mem_wb_rd : ex_wb_rd;
  assign g_data = mem_grant ? mem_wb_data : ex_wb_data;
  assign g_nz = (ex_grant | mem_grant) & (g_rd != ADDR_W'(ZERO_REG));
`ifdef SCB_BYPASS_EN
  assign view = pend & ~clr;
`else
  assign view = pend;
`endif
  // pend[ZERO_REG] is never set, so it always reads 0
  assign haz = (iss_rn_used & view[iss_rn]) | (iss_rm_used & view[iss_rm]) | (iss_rd_write & view[iss_rd]);
  assign iss_ready = !haz;
  assign fire = iss_valid & iss_ready & iss_rd_write & (iss_rd != ADDR_W'(ZERO_REG));
  // set is applied after clear so a forced same-register collision leaves it pending
  always_comb begin
    clr = '0;
    set = '0;
    clr[g_rd] = g_nz;
    set[iss_rd] = fire;
    pend_n = flush ? '0 : (pend & ~clr) | set;
    pc = '0;
    for (int i = 0; i < NUM_REGS; i++) pc = pc + 6'(pend_n[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      pend_cnt <= '0;
      starve <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      pend <= pend_n;
      pend_cnt <= pc;
      starve <= (ex_wb_valid & !ex_grant) ? starve + SW'(1) : '0;
      rf_we <= g_nz;
      if (g_nz) begin
        rf_waddr <= g_rd;
        rf_wdata <= g_data;
      end
      wb_err <= wb_err | (g_nz & !pend[g_rd]);
      stall_cnt <= stall_cnt + 16'(iss_valid & haz & ~&stall_cnt);
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Controller for the 32x64 general register file; sits between decode/issue and the register-file write port.
- Tracks a pending-write bit per register and stalls issue on RAW/WAW hazards.
- Arbitrates the single register-file write port between the EX (ALU) writeback source and the MEM (load) writeback source.
- Register X31 is hard zero: never pending, never written.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register index width.
- DATA_W, 64, register data width.
- ZERO_REG, 31, index of the hard-zero register.
- STARVE_LIMIT, 4, consecutive EX-lost cycles before EX is forced to win the write port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  decode presents an instruction.
- iss_ready  out  1  instruction may issue this cycle.
- iss_rn, iss_rm, iss_rd  in  ADDR_W  source 1, source 2 and destination indices.
- iss_rn_used, iss_rm_used  in  1  the corresponding source is read.
- iss_rd_write  in  1  instruction writes rd (RegWrite).
- ex_wb_valid, ex_wb_ready  in/out  1  EX writeback handshake.
- ex_wb_rd  in  ADDR_W, ex_wb_data  in  DATA_W  EX writeback index and data.
- mem_wb_valid, mem_wb_ready  in/out  1  MEM writeback handshake.
- mem_wb_rd  in  ADDR_W, mem_wb_data  in  DATA_W  MEM writeback index and data.
- flush  in  1  synchronous clear of all pending bits.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  ADDR_W, rf_wdata  out  DATA_W  register-file write index and data.
- pend_cnt  out  6  number of pending registers.
- stall_cnt  out  16  saturating count of hazard-stall cycles.
- wb_err  out  1  sticky flag: writeback to a register that was not pending.

Behaviour:
- Reset (rst_n low, asynchronous): pend[*]=0, rf_we=0, rf_waddr=0, rf_wdata=0, pend_cnt=0, stall_cnt=0, wb_err=0, starvation counter=0.
- Hazard:
  - haz = (iss_rn_used & pend[iss_rn]) | (iss_rm_used & pend[iss_rm]) | (iss_rd_write & pend[iss_rd]).
  - pend[ZERO_REG] always reads 0.
  - iss_ready = !haz, combinational from registered pend. iss_valid is not required for iss_ready.
- Issue fires on iss_valid & iss_ready; it sets pend[iss_rd] if iss_rd_write and iss_rd != ZERO_REG.
- Arbitration:
  - Default priority is MEM. ex_wb_ready = !mem_wb_valid | force_ex; mem_wb_ready = !force_ex | !ex_wb_valid.
  - Starvation counter increments each cycle ex_wb_valid and EX loses. It resets to 0 when EX wins or ex_wb_valid=0.
  - force_ex = (counter == STARVE_LIMIT).
- Grant:
  - The granted source's rd is cleared in pend at the clock edge of grant.
  - rf_we/rf_waddr/rf_wdata are registered: asserted the cycle after grant, for exactly one cycle (1-cycle write latency).
  - If the granted rd == ZERO_REG, the handshake completes, rf_we stays 0 and pend is unchanged.
  - A grant to a non-pending register (not ZERO_REG) still writes the register file and sets wb_err=1; wb_err clears only on reset.
- Same-edge events:
  - Issue set and grant clear on the same register in the same cycle cannot occur (WAW stall). If they are forced anyway, set wins.
  - Issue set and grant clear on different registers in the same cycle both apply.
- Flush: all pend bits go to 0 at the next edge, overriding an issue set in the same cycle. A grant in the flush cycle still produces its rf_we the following cycle.
- pend_cnt = popcount(pend), registered, range 0..31.
- stall_cnt increments each cycle iss_valid & !iss_ready and saturates at 0xFFFF.

Optional Feature:
- Macro SCB_BYPASS_EN.
- Defined: the hazard check uses pend with this cycle's grant clear already applied, so an instruction waiting on rd issues in the grant cycle (zero bubble).
- Undefined: the hazard check uses registered pend only, so a waiting instruction issues one cycle after the grant cycle.

Test Plan:
- Reset mid-traffic:
  - Stimulus: set pend[3], pend[7]; assert rst_n=0 between clock edges.
  - Response: all outputs 0 immediately; an issue reading x3 then has iss_ready=1.
- RAW stall:
  - Stimulus: issue rd=5 write; next cycle issue rn=5; EX writeback rd=5 data=0xDEAD granted at cycle 3.
  - Response: iss_ready=0 until pend[5] clears; rf_we=1, rf_waddr=5, rf_wdata=0xDEAD at cycle 4.
  - Issue resumes at cycle 4 without the macro, cycle 3 with SCB_BYPASS_EN.
- Simultaneous writeback:
  - Stimulus: EX rd=1 and MEM rd=2 valid in the same cycle.
  - Response: MEM granted first (rf_waddr=2); EX granted the next cycle (rf_waddr=1).
- Starvation:
  - Stimulus: MEM valid every cycle, EX held valid, STARVE_LIMIT=4.
  - Response: EX granted on its 5th waiting cycle and mem_wb_ready=0 that cycle.
- Zero register and error:
  - Stimulus: issue rd=31; writeback rd=31; writeback rd=9 while pend[9]=0.
  - Response: pend_cnt stays 0; no rf_we for rd=31; rd=9 is written and wb_err=1.
- Flush and saturation:
  - Stimulus: pend x1..x4 then flush; separately, hold a stall for 70000 cycles.
  - Response: pend_cnt=0 after the flush; stall_cnt=0xFFFF after the held stall.
